// File: rtl/demux1to2_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry output register per channel.
// Optional per-channel delivery counters are enabled by defining DEMUX_CNT_EN.
module demux1to2_reg #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sel,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DWIDTH-1:0] a_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DWIDTH-1:0] b_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CWIDTH-1:0] a_count,
    output logic [CWIDTH-1:0] b_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t       r_a_state;
    chan_state_t       r_b_state;
    chan_state_t       w_a_state_nxt;
    chan_state_t       w_b_state_nxt;
    logic [DWIDTH-1:0] r_a_data;
    logic [DWIDTH-1:0] r_b_data;
    logic              w_a_room;
    logic              w_b_room;
    logic              w_in_xfer;
    logic              w_a_load;
    logic              w_b_load;
    logic              w_a_out;
    logic              w_b_out;

    // Acceptance looks only at the selected channel; held low during reset.
    assign w_a_room  = (r_a_state == EMPTY) | a_ready;
    assign w_b_room  = (r_b_state == EMPTY) | b_ready;
    assign in_ready  = rst_n & (in_sel ? w_b_room : w_a_room);
    assign w_in_xfer = in_valid & in_ready;
    assign w_a_load  = w_in_xfer & ~in_sel;
    assign w_b_load  = w_in_xfer & in_sel;
    assign w_a_out   = (r_a_state == FULL) & a_ready;
    assign w_b_out   = (r_b_state == FULL) & b_ready;

    assign a_valid = (r_a_state == FULL);
    assign b_valid = (r_b_state == FULL);
    assign a_data  = r_a_data;
    assign b_data  = r_b_data;

    // Channel A next-state: a routed load always leaves the channel full.
    always_comb begin
        w_a_state_nxt = r_a_state;
        case (r_a_state)
            EMPTY: begin
                if (w_a_load) w_a_state_nxt = FULL;
                else          w_a_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_a_out && !w_a_load) w_a_state_nxt = EMPTY;
                else                      w_a_state_nxt = FULL;
            end
            default: w_a_state_nxt = EMPTY;
        endcase
    end

    // Channel B next-state, mirror of channel A.
    always_comb begin
        w_b_state_nxt = r_b_state;
        case (r_b_state)
            EMPTY: begin
                if (w_b_load) w_b_state_nxt = FULL;
                else          w_b_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_b_out && !w_b_load) w_b_state_nxt = EMPTY;
                else                      w_b_state_nxt = FULL;
            end
            default: w_b_state_nxt = EMPTY;
        endcase
    end

    // Channel state and data registers; data holds its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_state <= EMPTY;
            r_b_state <= EMPTY;
            r_a_data  <= {DWIDTH{1'b0}};
            r_b_data  <= {DWIDTH{1'b0}};
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
            if (w_a_load) r_a_data <= in_data;
            else          r_a_data <= r_a_data;
            if (w_b_load) r_b_data <= in_data;
            else          r_b_data <= r_b_data;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CWIDTH-1:0] r_a_count;
    logic [CWIDTH-1:0] r_b_count;

    assign a_count = r_a_count;
    assign b_count = r_b_count;

    // Delivery counters, wrapping naturally at 2^CWIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= {CWIDTH{1'b0}};
            r_b_count <= {CWIDTH{1'b0}};
        end else begin
            if (w_a_out) r_a_count <= r_a_count + CWIDTH'(1'b1);
            else         r_a_count <= r_a_count;
            if (w_b_out) r_b_count <= r_b_count + CWIDTH'(1'b1);
            else         r_b_count <= r_b_count;
        end
    end
`endif

endmodule

// File: tb/tb_demux1to2_reg.sv
// Self-checking bench for demux1to2_reg: directed scenarios plus random traffic
// against a queue-based reference model. Counter checks apply when DEMUX_CNT_EN is defined.
module tb_demux1to2_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
`ifdef DEMUX_CNT_EN
    logic [3:0]  a_count;
    logic [3:0]  b_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a FIFO of at most one word.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          cnt_a;
    int          cnt_b;

    demux1to2_reg #(.DWIDTH(32), .CWIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_CNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        qa.delete();
        qb.delete();
        last_a = 32'h0;
        last_b = 32'h0;
        cnt_a  = 0;
        cnt_b  = 0;
    endtask

    task automatic chk_outputs();
        chk("a_valid", 64'(a_valid), 64'(qa.size() != 0));
        chk("b_valid", 64'(b_valid), 64'(qb.size() != 0));
        chk("a_data", 64'(a_data), 64'((qa.size() != 0) ? qa[0] : last_a));
        chk("b_data", 64'(b_data), 64'((qb.size() != 0) ? qb[0] : last_b));
`ifdef DEMUX_CNT_EN
        chk("a_count", 64'(a_count), 64'(cnt_a));
        chk("b_count", 64'(b_count), 64'(cnt_b));
`endif
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic cyc();
        logic exp_rdy;
        logic xin;
        logic pa;
        logic pb;
        #1;
        exp_rdy = in_sel ? ((qb.size() == 0) || b_ready) : ((qa.size() == 0) || a_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        xin = in_valid && exp_rdy;
        pa  = (qa.size() != 0) && a_ready;
        pb  = (qb.size() != 0) && b_ready;
        @(posedge clk);
        if (pa) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 16; end
        if (pb) begin void'(qb.pop_front()); cnt_b = (cnt_b + 1) % 16; end
        if (xin) begin
            if (in_sel) begin qb.push_back(in_data); last_b = in_data; end
            else        begin qa.push_back(in_data); last_a = in_data; end
        end
        #1;
        chk_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst in_ready", 64'(in_ready), 64'(1'b0));
        chk_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // T1: reset with in_valid high
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_reset();

        // T2: route one word to A then one to B
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        cyc();
        chk("T2 a_data", 64'(a_data), 64'(32'hDEAD_BEEF));
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        cyc();
        chk("T2 b_data", 64'(b_data), 64'(32'h1234_5678));
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc();

        // T3: A stalled and full; B traffic still flows
        drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        #1;
        chk("T3 blocked ready", 64'(in_ready), 64'(1'b0));
        cyc();
        drive(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        cyc();
        chk("T3 b_data", 64'(b_data), 64'(32'h3));
        chk("T3 a_data", 64'(a_data), 64'(32'h1));
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc();

        // T4: back-to-back full throughput on A
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            #1;
            chk("T4 ready", 64'(in_ready), 64'(1'b1));
            cyc();
            chk("T4 a_data", 64'(a_data), 64'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc();

        // T5: asynchronous reset with both channels full
        drive(1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        cyc();
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("T5 a_valid drop", 64'(a_valid), 64'(1'b0));
        chk("T5 b_valid drop", 64'(b_valid), 64'(1'b0));
        chk("T5 ready in rst", 64'(in_ready), 64'(1'b0));
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_00A5, 1'b1, 1'b1);
        cyc();
        chk("T5 first accept", 64'(a_valid), 64'(1'b1));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom(),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            cyc();
        end

        // T6: counter wrap, 17 A and 3 B deliveries
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, (i >= 17) ? 1'b1 : 1'b0, 32'(i + 100), 1'b1, 1'b1);
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc();
        cyc();
`ifdef DEMUX_CNT_EN
        chk("T6 a_count", 64'(a_count), 64'(4'd1));
        chk("T6 b_count", 64'(b_count), 64'(4'd3));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
